// File: rtl/data_ram_arb_pkg.sv
// data_ram_arb_pkg
//   Shared types and defaults for the data RAM arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, LOCKED)
//   - port_e      : requester ids used by the round-robin "last" flag
//   - DEF_ADDR_W / DEF_DATA_W : default RAM geometry
package data_ram_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

endpackage

// File: rtl/data_ram_arbiter_lock_timer.sv
// lock_timer
//   Session length counter for a host lock. Loaded to 1 on the lock entry
//   edge, incremented on each enabled LOCKED edge that does not end the
//   session. o_tc flags the last allowed LOCKED cycle (count == BURST_MAX-1).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : start a session (count <- 1)
//   i_inc          : advance the session count
//   o_tc           : terminal count reached
module lock_timer #(
  parameter int BURST_MAX = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [7:0] TC = 8'(BURST_MAX - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_cnt <= 8'd0;
    else if (i_load) r_cnt <= 8'd1;
    else if (i_inc)  r_cnt <= r_cnt + 8'd1;
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single-port data RAM between the CPU data port and the host
//   loader port. Round-robin per access in IDLE; the host may take a bounded
//   exclusive lock (LOCKED) for bursts. Read responses return one cycle after
//   the grant and are steered back to the issuing port by a per-port tag.
// Ports:
//   clk_in, reset            : clock, synchronous active-high reset
//   enable                   : low = no grants, arbitration state frozen
//   cpu_*  (req/we/addr/wdata -> gnt/rvalid/rdata) : CPU port
//   host_* (req/we/lock/addr/wdata -> gnt/rvalid/rdata) : host port
//   data_w/addr_data_ram/din_data_ram -> RAM, dout_data_ram <- RAM
//   busy                     : high while LOCKED
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              data_w,
  output logic [ADDR_W-1:0] addr_data_ram,
  output logic [DATA_W-1:0] din_data_ram,
  input  logic [DATA_W-1:0] dout_data_ram,
  output logic              busy
);

  arb_state_e r_state;
  port_e      r_last;
  logic [1:0] r_rtag;   // [0] CPU read outstanding, [1] host read outstanding

  logic w_run;
  logic w_cpu_gnt;
  logic w_host_gnt;
  logic w_lock_entry;
  logic w_lock_exit;
  logic w_lock_inc;
  logic w_tc;

  assign w_run = enable & ~reset;

  // Grants are combinational so the RAM sees the access in the request cycle.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (w_run) begin
      if (r_state == LOCKED) begin
        w_host_gnt = host_req;
      end else if (cpu_req && host_req) begin
        // Tie: the port that was not served last wins.
        if (r_last == PORT_HOST) w_cpu_gnt  = 1'b1;
        else                     w_host_gnt = 1'b1;
      end else begin
        w_cpu_gnt  = cpu_req;
        w_host_gnt = host_req;
      end
    end
  end

  // RAM mux; grants are mutually exclusive so priority order is irrelevant.
  always_comb begin
    data_w        = 1'b0;
    addr_data_ram = '0;
    din_data_ram  = '0;
    if (w_cpu_gnt) begin
      data_w        = cpu_we;
      addr_data_ram = cpu_addr;
      din_data_ram  = cpu_wdata;
    end else if (w_host_gnt) begin
      data_w        = host_we;
      addr_data_ram = host_addr;
      din_data_ram  = host_wdata;
    end
  end

  // Lock session control. The session ends on the first LOCKED edge where the
  // host drops its lock or the timer reaches its terminal count, whether or
  // not the host is actually accessing the RAM, which bounds the CPU stall.
  assign w_lock_entry = (r_state == IDLE) && w_host_gnt && host_lock;
  assign w_lock_exit  = (r_state == LOCKED) && (!host_lock || w_tc);
  assign w_lock_inc   = w_run && (r_state == LOCKED) && !w_lock_exit;

  lock_timer #(
    .BURST_MAX (BURST_MAX)
  ) u_lock_timer (
    .i_clk   (clk_in),
    .i_reset (reset),
    .i_load  (w_lock_entry),
    .i_inc   (w_lock_inc),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= PORT_HOST;
      r_rtag  <= 2'b00;
    end else begin
      // Read tags track the RAM's one-cycle latency; they run even when
      // disabled so an in-flight response is still delivered.
      r_rtag <= {w_host_gnt & ~host_we, w_cpu_gnt & ~cpu_we};
      if (enable) begin
        if (w_cpu_gnt)       r_last <= PORT_CPU;
        else if (w_host_gnt) r_last <= PORT_HOST;
        case (r_state)
          IDLE: begin
            if (w_lock_entry) r_state <= LOCKED;
          end
          LOCKED: begin
            if (w_lock_exit) begin
              r_state <= IDLE;
              r_last  <= PORT_HOST;   // CPU gets the first tie after a session
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign host_gnt    = w_host_gnt;
  assign cpu_rvalid  = r_rtag[0] & ~reset;
  assign host_rvalid = r_rtag[1] & ~reset;
  assign cpu_rdata   = cpu_rvalid  ? dout_data_ram : '0;
  assign host_rdata  = host_rvalid ? dout_data_ram : '0;
  assign busy        = (r_state == LOCKED) & ~reset;

endmodule
